// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the word-indexed imem, fills IF/ID.
// Optional FETCH_PERF_EN macro adds fetch/stall performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_count,
    output logic [31:0] perf_stall_count
`endif
);

    logic [31:0] pc_q, pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;

    logic        jmp;
    logic        load_en;
    logic [31:0] jump_target;
    logic [31:0] pc_plus4;

    // J (000010) and JAL (000011) differ only in opcode bit 26.
    assign jmp         = ifid_valid_q && (ifid_instr_q[31:27] == 5'b00001);
    assign jump_target = {ifid_pc_plus4_q[31:28], ifid_instr_q[25:0], 2'b00};
    assign pc_plus4    = pc_q + 32'd4;
    assign load_en     = !redirect_valid && !stall;

    always_comb begin
        pc_d            = pc_q;
        ifid_valid_d    = ifid_valid_q;
        ifid_instr_d    = ifid_instr_q;
        ifid_pc_d       = ifid_pc_q;
        ifid_pc_plus4_d = ifid_pc_plus4_q;
        if (redirect_valid) begin
            // Flush leaves ifid_pc/ifid_pc_plus4 untouched; only valid/instr are cleared.
            pc_d         = {redirect_target[31:2], 2'b00};
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end else if (load_en) begin
            ifid_valid_d    = 1'b1;
            ifid_instr_d    = imem_instr;
            ifid_pc_d       = pc_q;
            ifid_pc_plus4_d = pc_plus4;
            pc_d            = jmp ? jump_target : pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q            <= {RESET_PC[31:2], 2'b00};
            ifid_valid_q    <= 1'b0;
            ifid_instr_q    <= NOP_INSTR;
            ifid_pc_q       <= 32'd0;
            ifid_pc_plus4_q <= 32'd0;
        end else begin
            pc_q            <= pc_d;
            ifid_valid_q    <= ifid_valid_d;
            ifid_instr_q    <= ifid_instr_d;
            ifid_pc_q       <= ifid_pc_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
        end
    end

    assign imem_addr     = {2'b00, pc_q[31:2]};
    assign pc            = pc_q;
    assign ifid_valid    = ifid_valid_q;
    assign ifid_instr    = ifid_instr_q;
    assign ifid_pc       = ifid_pc_q;
    assign ifid_pc_plus4 = ifid_pc_plus4_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q + {31'd0, load_en};
        stall_count_d = stall_count_q + {31'd0, (!redirect_valid && stall)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= 32'd0;
            stall_count_q <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign perf_fetch_count = fetch_count_q;
    assign perf_stall_count = stall_count_q;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS pipeline. Owns the program counter and drives the word address into the combinational, word-indexed instruction memory. Registers the returned instruction into the IF/ID pipeline register for decode. Handles pipeline stall, flush/redirect from later stages, and early J/JAL redirection with one architectural delay slot.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000: instruction word inserted into IF/ID on flush/reset (sll $0,$0,0).

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- imem_addr  output  32  word address to instruction memory: {2'b00, pc[31:2]}.
- imem_instr  input  32  instruction returned combinationally for imem_addr, same cycle.
- stall  input  1  hazard unit hold request: freeze PC and IF/ID.
- redirect_valid  input  1  branch/exception redirect from a later stage.
- redirect_target  input  32  byte address for the redirect; bits [1:0] are ignored and forced to 0.
- pc  output  32  current fetch PC (byte address).
- ifid_valid  output  1  IF/ID holds a real instruction.
- ifid_instr  output  32  registered instruction.
- ifid_pc  output  32  PC of ifid_instr.
- ifid_pc_plus4  output  32  ifid_pc + 4.
- perf_fetch_count  output  32  present only with FETCH_PERF_EN.
- perf_stall_count  output  32  present only with FETCH_PERF_EN.

## Operation
- Early jump condition (jmp): ifid_valid=1 and ifid_instr[31:26] is 6'b000010 (J) or 6'b000011 (JAL).
- Jump target: {ifid_pc_plus4[31:28], ifid_instr[25:0], 2'b00}.
- Per-cycle update, evaluated in strict priority order:
  1. reset: pc <= RESET_PC. ifid_valid <= 0, ifid_instr <= NOP_INSTR, ifid_pc <= 0, ifid_pc_plus4 <= 0. Counters <= 0.
  2. redirect_valid: pc <= {redirect_target[31:2], 2'b00}. ifid_valid <= 0 and ifid_instr <= NOP_INSTR (flush). ifid_pc/ifid_pc_plus4 hold. The redirect overrides a simultaneous stall and a pending jmp.
  3. stall: pc and every IF/ID field hold. A jmp in IF/ID stays pending.
  4. jmp: IF/ID loads the delay-slot instruction normally (ifid_instr <= imem_instr, ifid_pc <= pc, ifid_pc_plus4 <= pc+4, ifid_valid <= 1). pc <= jump target.
  5. Otherwise: IF/ID loads as in step 4, and pc <= pc + 4.
- A jmp is acted on exactly once: the next cycle IF/ID holds the delay slot, not the jump.
- Arithmetic: all PC adds are 32-bit modulo 2^32. pc=32'hFFFF_FFFC wraps to 0. imem_addr wraps with it.
- pc[1:0] is always 0.
- Memory beyond 1024 words is the memory's concern. The fetch stage does not truncate the address.

## Timing
- imem_addr is combinational from the pc register. imem_instr must be valid the same cycle.
- Fetch-to-IF/ID latency: 1 cycle. An instruction at pc in cycle N appears on ifid_instr in cycle N+1.
- Redirect penalty: 1 bubble. Target fetched in the cycle after redirect_valid. First valid target in IF/ID 2 cycles after redirect_valid.
- Jump: 0 bubbles (delay slot fills the slot). Target fetched the cycle after the delay slot is fetched.
- Reset deasserted in cycle N: imem_addr = RESET_PC>>2 during cycle N. ifid_valid=1 from N+1 (absent stall/redirect).
- Reset asserted mid-operation overrides stall, redirect and jmp in the same cycle.

## Configuration
- FETCH_PERF_EN defined:
  - perf_fetch_count increments on every cycle where IF/ID loads (priority steps 4/5).
  - perf_stall_count increments on every cycle where step 3 applies.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- FETCH_PERF_EN undefined: both ports and all counter logic are absent. Functional behaviour is identical.

## Test plan
- Reset then free-run, memory words 0..3 = A,B,C,D: imem_addr 0,1,2,3. ifid_instr A,B,C one cycle later. ifid_pc 0,4,8.
- Stall for 3 cycles while pc=8: pc stays 8 and ifid_instr stays B for 3 cycles. Fetch resumes at C with no skipped or duplicated instruction.
- redirect_valid with redirect_target=32'h0000_0043 while stall=1: next pc=32'h40. Next cycle ifid_valid=0 and ifid_instr=NOP. Then ifid_instr=mem[16], ifid_pc=32'h40.
- J with instr[25:0]=26'h000_0020 at pc 0, delay slot at pc 4: IF/ID sequence J, slot (ifid_pc=4), then instruction at pc 32'h80.
- J in IF/ID with stall=1 for 2 cycles: no redirect while stalled. Jump taken on the first unstalled cycle.
- Set pc=32'hFFFF_FFFC via redirect, then run: next pc=0. With FETCH_PERF_EN, the counters match the counted loads and stalls across all scenarios.
